// File: rtl/bitwise_logic_pkg.sv
// Op codes and per-bit helper functions shared by the bitwise logic pipeline.
// Functions work on single bits so callers can replicate them across any WIDTH.
package bitwise_logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NOR     = 3'd3,
    OP_NAND    = 3'd4,
    OP_XNOR    = 3'd5,
    OP_ACC_OR  = 3'd6,
    OP_ACC_XOR = 3'd7
  } op_e;

  function automatic logic is_acc(input logic [OP_W-1:0] op);
    return (op == OP_ACC_OR) || (op == OP_ACC_XOR);
  endfunction

  // For the accumulate ops this yields the per-beat term (a|b or a^b) that is folded into acc.
  function automatic logic apply_op(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOR:    r = ~(a | b);
      OP_NAND:   r = ~(a & b);
      OP_XNOR:   r = ~(a ^ b);
      OP_ACC_OR: r = a | b;
      default:   r = a ^ b;
    endcase
    return r;
  endfunction

  function automatic logic fold_bit(input logic [OP_W-1:0] op, input logic acc, input logic term);
    return (op == OP_ACC_OR) ? (acc | term) : (acc ^ term);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Single-entry valid/ready register slot; loads when empty or when its
// current contents leave in the same cycle, so a chain of slots runs at full rate.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      if (in_ready) valid_reg <= in_valid;
      if (in_valid && in_ready) data_reg <= in_data;
    end
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise ops, with OR/XOR accumulate.
// Define BITWISE_LOGIC_PIPE_TRACE_EN to print a simulation line on every output transfer.
module bitwise_logic_pipe
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int S1_W = OP_W + 2 * WIDTH + 1;
  localparam int S2_W = WIDTH + 1;

  logic             s1_valid;
  logic             s1_leave;
  logic [S1_W-1:0]  s1_data;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_last;
  logic             s1_acc;
  logic             s1_consume;

  logic             s2_in_valid;
  logic             s2_ready;
  logic [S2_W-1:0]  s2_in_data;
  logic [S2_W-1:0]  s2_data;

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] fold_res;

  pipe_slot #(.W(S1_W)) u_s1 (
    .clk       (CLK),
    .srst      (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_a, in_b, in_last}),
    .out_valid (s1_valid),
    .out_ready (s1_leave),
    .out_data  (s1_data)
  );

  assign {s1_op, s1_a, s1_b, s1_last} = s1_data;
  assign s1_acc     = is_acc(s1_op);
  // Non-final accumulate beats retire into acc, so they never wait on S2.
  assign s1_consume = s1_valid && s1_acc && !s1_last;
  assign s1_leave   = s1_consume || s2_ready;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign op_res[gi]   = apply_op(s1_op, s1_a[gi], s1_b[gi]);
      assign fold_res[gi] = fold_bit(s1_op, acc_reg[gi], op_res[gi]);
    end
  endgenerate

  assign s2_in_valid = s1_valid && !s1_consume;
  assign s2_in_data  = s1_acc ? {1'b1, fold_res} : {1'b0, op_res};

  pipe_slot #(.W(S2_W)) u_s2 (
    .clk       (CLK),
    .srst      (RST),
    .in_valid  (s2_in_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {out_last, out_data} = s2_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_reg <= '0;
    end else if (s1_valid && s1_acc) begin
      if (!s1_last) acc_reg <= fold_res;
      else if (s2_ready) acc_reg <= '0;
    end
  end

`ifdef BITWISE_LOGIC_PIPE_TRACE_EN
  logic [2:0]       trace_op_reg;
  logic [WIDTH-1:0] trace_a_reg;
  logic [WIDTH-1:0] trace_b_reg;

  // Shadow of the operands that produced the result currently held in S2.
  always_ff @(posedge CLK) begin
    if (s2_in_valid && s2_ready) begin
      trace_op_reg <= s1_op;
      trace_a_reg  <= s1_a;
      trace_b_reg  <= s1_b;
    end
  end

  always @(posedge CLK) begin
    if (!RST && out_valid && out_ready)
      $display("%2d: op=%0d %b %b -> %b last=%b", $time, trace_op_reg, trace_a_reg,
               trace_b_reg, out_data, out_last);
  end
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: directed steps plus random traffic
// scored against a queue-based reference model of the op/accumulate rules.
module tb_bitwise_logic_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;

  logic        in_valid16;
  logic        in_ready16;
  logic [2:0]  in_op16;
  logic [15:0] in_a16;
  logic [15:0] in_b16;
  logic        in_last16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] out_data16;
  logic        out_last16;

  int n_cmp = 0;
  int n_err = 0;
  logic rnd_ready = 1'b0;

  logic [4:0] exp_q[$];
  logic [3:0] macc = 4'd0;
  logic       prev_stall = 1'b0;
  logic [4:0] prev_out = 5'd0;

  bitwise_logic_pipe #(.WIDTH(4)) dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  bitwise_logic_pipe #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_op(in_op16),
    .in_a(in_a16), .in_b(in_b16), .in_last(in_last16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .out_last(out_last16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the op table applied with whole-word operators.
  function automatic logic [3:0] ref_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Scoreboard: accepted beats feed the model, transferred results are popped and compared.
  always @(negedge clk) begin
    logic [3:0] r;
    logic [3:0] f;
    logic [4:0] e;
    if (rst) begin
      exp_q.delete();
      macc = 4'd0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_out}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 32'({out_last, out_data}), 32'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
      if (in_valid && in_ready) begin
        r = ref_op(in_op, in_a, in_b);
        f = (in_op == 3'd6) ? (macc | r) : (macc ^ r);
        if (in_op < 3'd6) exp_q.push_back({1'b0, r});
        else if (!in_last) macc = f;
        else begin
          exp_q.push_back({1'b1, f});
          macc = 4'd0;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic last, output int waits);
    waits = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_last = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits >= 100) begin
        chk("send_timeout", 32'(waits), 32'd0);
        break;
      end
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(input string tag, input logic [3:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    int idx;
    logic [2:0] t4_op [3];
    t4_op[0] = 3'd0; t4_op[1] = 3'd1; t4_op[2] = 3'd2;

    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 4'd0; in_b = 4'd0; in_last = 1'b0;
    out_ready = 1'b1;
    in_valid16 = 1'b0; in_op16 = 3'd0; in_a16 = 16'd0; in_b16 = 16'd0; in_last16 = 1'b0;
    out_ready16 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);

    // 1: OR with exact two-edge latency
    in_valid = 1'b1; in_op = 3'd1; in_a = 4'b1010; in_b = 4'b1100; in_last = 1'b0;
    @(negedge clk);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n2", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'b1110);
    chk("t1_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    drain("t1");

    // 2: back-to-back ops 0..5, never stalled
    for (int i = 0; i < 6; i++) begin
      send(3'(i), 4'b1010, 4'b1100, 1'b0, w);
      chk("t2_no_wait", 32'(w), 32'd0);
    end
    drain("t2");

    // 3: ACC_OR sequence, then a lone closing beat proves acc was cleared
    send(3'd6, 4'b0001, 4'b0000, 1'b0, w);
    send(3'd6, 4'b0010, 4'b0000, 1'b0, w);
    send(3'd6, 4'b0000, 4'b1000, 1'b1, w);
    wait_out("t3_acc", 4'b1011, 1'b1);
    send(3'd6, 4'b0000, 4'b0000, 1'b1, w);
    wait_out("t3_cleared", 4'b0000, 1'b1);
    drain("t3");

    // 4: sink stalled for 5 cycles with 3 beats offered
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin
        in_op = t4_op[idx]; in_a = 4'b1010; in_b = 4'b1100; in_last = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("t4_accepted", 32'(idx), 32'd2);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(t4_op[2], 4'b1010, 4'b1100, 1'b0, w);
    drain("t4");

    // 5: reset mid-ACC and during a stall
    out_ready = 1'b0;
    send(3'd2, 4'b0110, 4'b0011, 1'b0, w);
    send(3'd7, 4'b0011, 4'b0101, 1'b0, w);
    send(3'd0, 4'b1111, 4'b1010, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(3'd7, 4'b1111, 4'b0000, 1'b1, w);
    wait_out("t5_acc_xor", 4'b1111, 1'b1);
    drain("t5");

    // Random traffic with random sink back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) == 0), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    drain("rand");

    // 6: WIDTH=16 XOR
    in_valid16 = 1'b1; in_op16 = 3'd2; in_a16 = 16'hA5A5; in_b16 = 16'hFFFF; in_last16 = 1'b0;
    @(negedge clk);
    chk("t6_in_ready", 32'(in_ready16), 32'd1);
    @(posedge clk); #1 in_valid16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_valid", 32'(out_valid16), 32'd1);
    chk("t6_data", 32'(out_data16), 32'h5A5A);
    chk("t6_last", 32'(out_last16), 32'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
